// File: rtl/trap_sequencer_if.sv
// Single-write-port CSR file bus: the sequencer (master) drives write/read
// address and data; the CSR file (slave) returns combinational read data.
interface trap_sequencer_if #(
  parameter int unsigned CSR_WIDTH      = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
);
  logic                      csr_we;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
  logic [CSR_WIDTH-1:0]      csr_wdata;
  logic [CSR_ADDR_WIDTH-1:0] csr_raddr;
  logic [CSR_WIDTH-1:0]      csr_rdata;
  logic [1:0]                csr_trap;

  modport master (
    output csr_we, csr_waddr, csr_wdata, csr_raddr, csr_trap,
    input  csr_rdata
  );

  modport slave (
    input  csr_we, csr_waddr, csr_wdata, csr_raddr, csr_trap,
    output csr_rdata
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret exit sequencer. Owns the CSR write port while
// sequencing, stalls the core, and pulses a PC redirect in the final cycle.
module trap_sequencer #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned CSR_WIDTH      = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trap_req,
  input  logic                      trap_cause,
  input  logic [PC_WIDTH-1:0]       trap_pc,
  input  logic                      mret_req,
  input  logic                      inst_csr_we,
  input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_waddr,
  input  logic [CSR_WIDTH-1:0]      inst_csr_wdata,
  input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_raddr,
  output logic [CSR_WIDTH-1:0]      inst_csr_rdata,
  output logic                      stall,
  output logic                      redirect_valid,
  output logic [PC_WIDTH-1:0]       redirect_pc,
  trap_sequencer_if.master          csr_bus
);

  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMstatus = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMtvec   = CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMepc    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] AddrMcause  = CSR_ADDR_WIDTH'(12'h342);
  localparam int unsigned BitMie  = 3;
  localparam int unsigned BitMpie = 7;

  typedef enum logic [2:0] {
    StIdle,
    StTEpc,
    StTCause,
    StTStat,
    StTVec,
    StRStat,
    StREpc
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                cause_q, cause_d;

  logic [CSR_WIDTH-1:0] epc_wdata;
  logic [PC_WIDTH-1:0]  rdata_pc;

  // Casts zero-extend or truncate between the pc and CSR widths.
  assign epc_wdata = CSR_WIDTH'(pc_q);
  assign rdata_pc  = PC_WIDTH'(csr_bus.csr_rdata);

  assign csr_bus.csr_trap = 2'b00;
  assign stall = (state_q != StIdle) | trap_req | mret_req;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    cause_d           = cause_q;
    csr_bus.csr_we    = 1'b0;
    csr_bus.csr_waddr = '0;
    csr_bus.csr_wdata = '0;
    csr_bus.csr_raddr = '0;
    inst_csr_rdata    = '0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;

    unique case (state_q)
      StIdle: begin
        // The trapping / mret instruction itself must never commit a CSR write.
        csr_bus.csr_we    = inst_csr_we & ~trap_req & ~mret_req;
        csr_bus.csr_waddr = inst_csr_waddr;
        csr_bus.csr_wdata = inst_csr_wdata;
        csr_bus.csr_raddr = inst_csr_raddr;
        inst_csr_rdata    = csr_bus.csr_rdata;
        if (trap_req) begin
          state_d = StTEpc;
          pc_d    = trap_pc;
          cause_d = trap_cause;
        end else if (mret_req) begin
          state_d = StRStat;
        end
      end
      StTEpc: begin
        csr_bus.csr_we    = 1'b1;
        csr_bus.csr_waddr = AddrMepc;
        csr_bus.csr_wdata = epc_wdata;
        state_d           = StTCause;
      end
      StTCause: begin
        csr_bus.csr_we    = 1'b1;
        csr_bus.csr_waddr = AddrMcause;
        csr_bus.csr_wdata = cause_q ? CSR_WIDTH'(2) : CSR_WIDTH'(11);
        state_d           = StTStat;
      end
      StTStat: begin
        csr_bus.csr_raddr          = AddrMstatus;
        csr_bus.csr_we             = 1'b1;
        csr_bus.csr_waddr          = AddrMstatus;
        csr_bus.csr_wdata          = csr_bus.csr_rdata;
        csr_bus.csr_wdata[BitMpie] = csr_bus.csr_rdata[BitMie];
        csr_bus.csr_wdata[BitMie]  = 1'b0;
        state_d                    = StTVec;
      end
      StTVec: begin
        // Direct mode only: mode bits are masked off the vector base.
        csr_bus.csr_raddr = AddrMtvec;
        redirect_valid    = 1'b1;
        redirect_pc       = {rdata_pc[PC_WIDTH-1:2], 2'b00};
        state_d           = StIdle;
      end
      StRStat: begin
        csr_bus.csr_raddr          = AddrMstatus;
        csr_bus.csr_we             = 1'b1;
        csr_bus.csr_waddr          = AddrMstatus;
        csr_bus.csr_wdata          = csr_bus.csr_rdata;
        csr_bus.csr_wdata[BitMie]  = csr_bus.csr_rdata[BitMpie];
        csr_bus.csr_wdata[BitMpie] = 1'b1;
        state_d                    = StREpc;
      end
      StREpc: begin
        csr_bus.csr_raddr = AddrMepc;
        redirect_valid    = 1'b1;
        redirect_pc       = rdata_pc;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: CSR file model, a queue-of-expected-cycles
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_trap_sequencer;

  logic        clk;
  logic        rst;
  logic        trap_req;
  logic        trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic        inst_csr_we;
  logic [11:0] inst_csr_waddr;
  logic [31:0] inst_csr_wdata;
  logic [11:0] inst_csr_raddr;
  logic [31:0] inst_csr_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  trap_sequencer_if #(.CSR_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

  trap_sequencer #(.PC_WIDTH(32), .CSR_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_req       (mret_req),
    .inst_csr_we    (inst_csr_we),
    .inst_csr_waddr (inst_csr_waddr),
    .inst_csr_wdata (inst_csr_wdata),
    .inst_csr_raddr (inst_csr_raddr),
    .inst_csr_rdata (inst_csr_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file model: one write port, combinational read.
  logic [31:0] csr_mem [0:4095];
  assign bus.csr_rdata = csr_mem[bus.csr_raddr];
  always @(posedge clk) if (bus.csr_we) csr_mem[bus.csr_waddr] <= bus.csr_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected sequencer cycle.
  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
  } step_t;

  step_t exp_q[$];

  function automatic step_t mk(logic we, logic [11:0] a, logic [31:0] d, logic rv, logic [31:0] p);
    step_t s;
    s.we = we; s.waddr = a; s.wdata = d; s.rv = rv; s.rpc = p;
    return s;
  endfunction

  // Reference model: idle pass-through, or replay the queued sequence.
  always @(negedge clk) begin
    logic [31:0] ms;
    step_t       s;
    chk("csr_trap", {30'd0, bus.csr_trap}, 32'd0);
    if (rst || exp_q.size() == 0) begin
      if (rst) exp_q.delete();
      chk("idle_we", {31'd0, bus.csr_we}, {31'd0, inst_csr_we & ~trap_req & ~mret_req});
      chk("idle_waddr", {20'd0, bus.csr_waddr}, {20'd0, inst_csr_waddr});
      chk("idle_wdata", bus.csr_wdata, inst_csr_wdata);
      chk("idle_rdata", inst_csr_rdata, csr_mem[inst_csr_raddr]);
      chk("idle_stall", {31'd0, stall}, {31'd0, trap_req | mret_req});
      chk("idle_rv", {31'd0, redirect_valid}, 32'd0);
      chk("idle_rpc", redirect_pc, 32'd0);
      if (!rst) begin
        ms = csr_mem[12'h300];
        if (trap_req) begin
          exp_q.push_back(mk(1'b1, 12'h341, trap_pc, 1'b0, 32'd0));
          exp_q.push_back(mk(1'b1, 12'h342, trap_cause ? 32'd2 : 32'd11, 1'b0, 32'd0));
          exp_q.push_back(mk(1'b1, 12'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0),
                             1'b0, 32'd0));
          exp_q.push_back(mk(1'b0, 12'h0, 32'd0, 1'b1, csr_mem[12'h305] & ~32'h3));
        end else if (mret_req) begin
          exp_q.push_back(mk(1'b1, 12'h300, (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0),
                             1'b0, 32'd0));
          exp_q.push_back(mk(1'b0, 12'h0, 32'd0, 1'b1, csr_mem[12'h341]));
        end
      end
    end else begin
      s = exp_q.pop_front();
      chk("seq_we", {31'd0, bus.csr_we}, {31'd0, s.we});
      if (s.we) begin
        chk("seq_waddr", {20'd0, bus.csr_waddr}, {20'd0, s.waddr});
        chk("seq_wdata", bus.csr_wdata, s.wdata);
      end
      chk("seq_stall", {31'd0, stall}, 32'd1);
      chk("seq_rdata", inst_csr_rdata, 32'd0);
      chk("seq_rv", {31'd0, redirect_valid}, {31'd0, s.rv});
      chk("seq_rpc", redirect_pc, s.rpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [11:0] a, input logic [31:0] d);
    inst_csr_we = 1'b1; inst_csr_waddr = a; inst_csr_wdata = d;
    tick();
    inst_csr_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
    rst = 1'b1; trap_req = 1'b0; trap_cause = 1'b0; trap_pc = 32'd0; mret_req = 1'b0;
    inst_csr_we = 1'b0; inst_csr_waddr = 12'd0; inst_csr_wdata = 32'd0; inst_csr_raddr = 12'd0;
    tick(); tick();
    chk("reset_we", {31'd0, bus.csr_we}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: idle pass-through write
    inst_csr_we = 1'b1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h80; #1;
    chk("t1_we", {31'd0, bus.csr_we}, 32'd1);
    chk("t1_stall", {31'd0, stall}, 32'd0);
    tick(); inst_csr_we = 1'b0;
    chk("t1_mtvec", csr_mem[12'h305], 32'h80);

    // 2: ecall at 0x40
    core_write(12'h305, 32'h100);
    core_write(12'h300, 32'h8);
    inst_csr_raddr = 12'h305; #1;
    chk("t2_rdata", inst_csr_rdata, 32'h100);
    trap_req = 1'b1; trap_cause = 1'b0; trap_pc = 32'h40;
    tick(); trap_req = 1'b0;
    tick(); tick(); tick();
    chk("t2_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t2_rpc", redirect_pc, 32'h100);
    tick();
    chk("t2_stall_drop", {31'd0, stall}, 32'd0);
    chk("t2_mepc", csr_mem[12'h341], 32'h40);
    chk("t2_mcause", csr_mem[12'h342], 32'd11);
    chk("t2_mstatus", csr_mem[12'h300], 32'h80);

    // 3: illegal at 0x7C with a colliding core write
    trap_req = 1'b1; trap_cause = 1'b1; trap_pc = 32'h7C;
    inst_csr_we = 1'b1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'hDEAD; #1;
    chk("t3_we_suppressed", {31'd0, bus.csr_we}, 32'd0);
    tick(); trap_req = 1'b0; inst_csr_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    chk("t3_stall_drop", {31'd0, stall}, 32'd0);
    chk("t3_mcause", csr_mem[12'h342], 32'd2);
    chk("t3_mepc", csr_mem[12'h341], 32'h7C);
    chk("t3_mtvec_kept", csr_mem[12'h305], 32'h100);

    // 4: mret to 0x44
    core_write(12'h341, 32'h44);
    core_write(12'h300, 32'h80);
    mret_req = 1'b1;
    tick(); mret_req = 1'b0;
    tick();
    chk("t4_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t4_rpc", redirect_pc, 32'h44);
    tick();
    chk("t4_mstatus", csr_mem[12'h300], 32'h88);
    chk("t4_stall_drop", {31'd0, stall}, 32'd0);

    // 5: simultaneous trap+mret, then an mret pulse mid-sequence
    trap_req = 1'b1; mret_req = 1'b1; trap_cause = 1'b0; trap_pc = 32'h90;
    tick(); trap_req = 1'b0; mret_req = 1'b0;
    mret_req = 1'b1;
    tick(); mret_req = 1'b0;
    tick(); tick();
    chk("t5_rpc", redirect_pc, 32'h100);
    tick(); tick(); tick();
    chk("t5_no_mret", {31'd0, redirect_valid}, 32'd0);
    chk("t5_mepc", csr_mem[12'h341], 32'h90);
    chk("t5_mstatus", csr_mem[12'h300], 32'h80);

    // 6: reset during T_CAUSE
    trap_req = 1'b1; trap_cause = 1'b1; trap_pc = 32'hA0;
    tick(); trap_req = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("t6_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_we", {31'd0, bus.csr_we}, 32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_redirect", {31'd0, redirect_valid}, 32'd0);
      tick();
    end
    chk("t6_mepc", csr_mem[12'h341], 32'hA0);
    chk("t6_mcause", csr_mem[12'h342], 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
